// File: rtl/fetch_unit_pkg.sv
// Shared constants, state encoding and next-PC target helper for the fetch front end.
package fetch_unit_pkg;

    localparam logic [1:0] PC_SEL_PC_PLUS_4 = 2'b00;
    localparam logic [1:0] PC_SEL_BRANCH    = 2'b01;
    localparam logic [1:0] PC_SEL_JAL       = 2'b10;
    localparam logic [1:0] PC_SEL_JALR      = 2'b11;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_S = 2'd0,
        WAIT_S  = 2'd1,
        HOLD_S  = 2'd2
    } fetch_state_e;

    // JALR targets have bit 0 cleared; BRANCH and JAL targets are used as given.
    function automatic logic [31:0] redirect_target(
        input logic [1:0]  sel,
        input logic [31:0] branch_target,
        input logic [31:0] jalr_target
    );
        if (sel == PC_SEL_JALR) begin
            return jalr_target & 32'hFFFF_FFFE;
        end
        return branch_target;
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry {pc, instr} buffer that parks a response arriving while IF/ID is stalled.
module fetch_hold_buf
    import fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_instr,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] instr
);

    // Clear wins over load so a redirect always empties the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            pc    <= 32'h0;
            instr <= NOP_INSTR;
        end else if (clear) begin
            valid <= 1'b0;
            pc    <= 32'h0;
            instr <= NOP_INSTR;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            instr <= load_instr;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, single-outstanding imem port, hold buffer and IF/ID register.
// Handshake: a request transfers when imem_req_o && imem_gnt_i in the same cycle; its response is
// one imem_rvalid_i pulse in a later cycle; rvalid is accepted unconditionally (no ready back-pressure).
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_stall_i,
    input  logic        if_id_stall_i,
    input  logic        if_id_flush_i,
    input  logic [1:0]  pc_sel_final_i,
    input  logic [31:0] branch_target_i,
    input  logic [31:0] jalr_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_instr_o,
    output logic        if_id_valid_o,
    output logic        fetch_busy_o,
    output logic [1:0]  fetch_state_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         discard_q, discard_d;

    logic         redirect;
    logic [31:0]  target;
    logic [31:0]  pc_plus4;

    logic         req;
    logic [31:0]  addr;
    logic         ifid_load;
    logic [31:0]  ifid_load_pc;
    logic [31:0]  ifid_load_instr;

    logic         buf_load;
    logic         buf_clear;
    logic         buf_valid;
    logic [31:0]  buf_pc;
    logic [31:0]  buf_instr;

    logic [31:0]  ifid_pc_q;
    logic [31:0]  ifid_instr_q;
    logic         ifid_valid_q;

    assign redirect = (pc_sel_final_i != PC_SEL_PC_PLUS_4);
    assign target   = redirect_target(pc_sel_final_i, branch_target_i, jalr_target_i);
    assign pc_plus4 = pc_q + 32'd4;

    fetch_hold_buf u_hold_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load),
        .clear      (buf_clear),
        .load_pc    (pc_q),
        .load_instr (imem_rdata_i),
        .valid      (buf_valid),
        .pc         (buf_pc),
        .instr      (buf_instr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH_S;
            pc_q      <= RESET_PC;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        discard_d       = discard_q;
        req             = 1'b0;
        addr            = pc_q;
        ifid_load       = 1'b0;
        ifid_load_pc    = pc_q;
        ifid_load_instr = imem_rdata_i;
        buf_load        = 1'b0;
        buf_clear       = 1'b0;

        case (state_q)
            FETCH_S: begin
                req = !pc_stall_i;
                if (req && imem_gnt_i) begin
                    state_d = WAIT_S;
                end
            end
            WAIT_S: begin
                if (imem_rvalid_i) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        state_d   = FETCH_S;
                    end else if (!redirect) begin
                        pc_d = pc_plus4;
                        if (if_id_stall_i) begin
                            buf_load = 1'b1;
                            state_d  = HOLD_S;
                        end else begin
                            ifid_load = 1'b1;
                            // Back-to-back issue keeps the port busy every cycle.
                            if (!pc_stall_i) begin
                                req     = 1'b1;
                                addr    = pc_plus4;
                                state_d = imem_gnt_i ? WAIT_S : FETCH_S;
                            end else begin
                                state_d = FETCH_S;
                            end
                        end
                    end
                end
            end
            HOLD_S: begin
                if (!if_id_stall_i) begin
                    ifid_load       = buf_valid;
                    ifid_load_pc    = buf_pc;
                    ifid_load_instr = buf_instr;
                    buf_clear       = 1'b1;
                    state_d         = FETCH_S;
                end
            end
            default: begin
                state_d = FETCH_S;
            end
        endcase

        // A redirect overrides everything; an outstanding request must still drain as a discard.
        if (redirect) begin
            pc_d      = target;
            buf_load  = 1'b0;
            buf_clear = 1'b1;
            ifid_load = 1'b0;
            case (state_q)
                FETCH_S: begin
                    if (req && imem_gnt_i) begin
                        state_d   = WAIT_S;
                        discard_d = 1'b1;
                    end else begin
                        state_d = FETCH_S;
                    end
                end
                WAIT_S: begin
                    if (imem_rvalid_i) begin
                        state_d   = FETCH_S;
                        discard_d = 1'b0;
                    end else begin
                        state_d   = WAIT_S;
                        discard_d = 1'b1;
                    end
                end
                default: begin
                    state_d = FETCH_S;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid_pc_q    <= 32'h0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
        end else if (redirect || if_id_flush_i) begin
            ifid_pc_q    <= 32'h0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
        end else if (if_id_stall_i) begin
            ifid_pc_q    <= ifid_pc_q;
            ifid_instr_q <= ifid_instr_q;
            ifid_valid_q <= ifid_valid_q;
        end else if (ifid_load) begin
            ifid_pc_q    <= ifid_load_pc;
            ifid_instr_q <= ifid_load_instr;
            ifid_valid_q <= 1'b1;
        end else begin
            ifid_pc_q    <= 32'h0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
        end
    end

    assign imem_req_o    = req && !rst;
    assign imem_addr_o   = addr;
    assign if_id_pc_o    = ifid_pc_q;
    assign if_id_instr_o = ifid_instr_q;
    assign if_id_valid_o = ifid_valid_q;
    assign fetch_busy_o  = (state_q == WAIT_S);
    assign fetch_state_o = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit: memory model plus program-order stream reference.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_stall_i;
    logic        if_id_stall_i;
    logic        if_id_flush_i;
    logic [1:0]  pc_sel_final_i;
    logic [31:0] branch_target_i;
    logic [31:0] jalr_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_instr_o;
    logic        if_id_valid_o;
    logic        fetch_busy_o;
    logic [1:0]  fetch_state_o;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .pc_stall_i      (pc_stall_i),
        .if_id_stall_i   (if_id_stall_i),
        .if_id_flush_i   (if_id_flush_i),
        .pc_sel_final_i  (pc_sel_final_i),
        .branch_target_i (branch_target_i),
        .jalr_target_i   (jalr_target_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_gnt_i      (imem_gnt_i),
        .imem_rvalid_i   (imem_rvalid_i),
        .imem_rdata_i    (imem_rdata_i),
        .if_id_pc_o      (if_id_pc_o),
        .if_id_instr_o   (if_id_instr_o),
        .if_id_valid_o   (if_id_valid_o),
        .fetch_busy_o    (fetch_busy_o),
        .fetch_state_o   (fetch_state_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // memory model
    bit          mem_pending;
    logic [31:0] mem_addr;
    int          mem_cnt;
    int unsigned gnt_pct;
    int unsigned lat_min;
    int unsigned lat_max;
    int          gnt_wait;
    int          req_age;
    bit          data_is_addr;

    // program-order stream reference
    logic [31:0] exp_pc;
    bit          exp_sync;
    int          loads;
    logic        last_req;
    logic [31:0] last_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (data_is_addr) return a;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        pc_stall_i      = 1'b0;
        if_id_stall_i   = 1'b0;
        if_id_flush_i   = 1'b0;
        pc_sel_final_i  = 2'b00;
        branch_target_i = 32'h0;
        jalr_target_i   = 32'h0;
        imem_gnt_i      = 1'b0;
        imem_rvalid_i   = 1'b0;
        imem_rdata_i    = 32'h0;
    endtask

    // Asynchronous reset, checked immediately; the memory forgets any outstanding request.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        idle_inputs();
        #1;
        check("rst_req", imem_req_o, 1'b0);
        check("rst_addr", imem_addr_o, 32'h0);
        check("rst_pc", if_id_pc_o, 32'h0);
        check("rst_instr", if_id_instr_o, NOP);
        check("rst_valid", if_id_valid_o, 1'b0);
        check("rst_busy", fetch_busy_o, 1'b0);
        mem_pending = 1'b0;
        mem_cnt     = 0;
        req_age     = 0;
        exp_pc      = 32'h0;
        exp_sync    = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock cycle: drive inputs, answer the port, then check IF/ID against the stream model.
    task automatic step(input bit ps, input bit ifs, input bit fl, input logic [1:0] sel,
                        input logic [31:0] bt, input logic [31:0] jt);
        logic [31:0] p_pc;
        logic [31:0] p_instr;
        logic        p_valid;
        logic        gnt;
        bit          rv;
        bit          redir;
        logic [31:0] tgt;
        p_pc    = if_id_pc_o;
        p_instr = if_id_instr_o;
        p_valid = if_id_valid_o;
        pc_stall_i      = ps;
        if_id_stall_i   = ifs;
        if_id_flush_i   = fl;
        pc_sel_final_i  = sel;
        branch_target_i = bt;
        jalr_target_i   = jt;
        rv = mem_pending && (mem_cnt == 0);
        imem_rvalid_i = rv;
        imem_rdata_i  = rv ? mem_word(mem_addr) : $urandom();
        imem_gnt_i    = 1'b0;
        #1;
        last_req  = imem_req_o;
        last_addr = imem_addr_o;
        gnt = 1'b0;
        if (last_req && (req_age >= gnt_wait) && ($urandom_range(0, 99) < gnt_pct)) gnt = 1'b1;
        imem_gnt_i = gnt;
        check("req_under_pc_stall", last_req && ps, 1'b0);
        if (last_req && gnt) check("one_outstanding", mem_pending && !rv, 1'b0);
        if (rv) mem_pending = 1'b0;
        else if (mem_pending) mem_cnt--;
        if (last_req && gnt) begin
            mem_pending = 1'b1;
            mem_addr    = last_addr;
            mem_cnt     = int'($urandom_range(lat_max, lat_min)) - 1;
            req_age     = 0;
        end else if (last_req) begin
            req_age++;
        end else begin
            req_age = 0;
        end
        redir = (sel != 2'b00);
        tgt   = (sel == 2'b11) ? (jt & 32'hFFFF_FFFE) : bt;
        @(posedge clk);
        @(negedge clk);
        if (redir || fl) begin
            check("bubble_pc", if_id_pc_o, 32'h0);
            check("bubble_instr", if_id_instr_o, NOP);
            check("bubble_valid", if_id_valid_o, 1'b0);
        end else if (ifs) begin
            check("hold_pc", if_id_pc_o, p_pc);
            check("hold_instr", if_id_instr_o, p_instr);
            check("hold_valid", if_id_valid_o, p_valid);
        end else if (if_id_valid_o) begin
            loads++;
            if (exp_sync) begin
                check("stream_pc", if_id_pc_o, exp_pc);
                check("stream_instr", if_id_instr_o, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
            end
        end
        if (redir) begin
            exp_pc   = tgt;
            exp_sync = 1'b1;
        end else if (fl) begin
            exp_sync = 1'b0;
        end
    endtask

    task automatic plain(input bit ps, input bit ifs);
        step(ps, ifs, 1'b0, 2'b00, 32'h0, 32'h0);
    endtask

    initial begin
        bit          ps;
        bit          ifs;
        bit          fl;
        logic [1:0]  sel;
        logic [31:0] bt;
        logic [31:0] jt;
        rst = 1'b1;
        idle_inputs();
        loads = 0;

        // zero-wait memory returning the address as data
        data_is_addr = 1'b1; gnt_pct = 100; lat_min = 1; lat_max = 1; gnt_wait = 0;
        do_reset();
        plain(1'b0, 1'b0);
        check("first_req", last_req, 1'b1);
        check("first_addr", last_addr, 32'h0);
        check("latency_1edge_valid", if_id_valid_o, 1'b0);
        plain(1'b0, 1'b0);
        check("latency_pc0", if_id_pc_o, 32'h0);
        check("latency_valid0", if_id_valid_o, 1'b1);
        for (int i = 1; i < 4; i++) begin
            plain(1'b0, 1'b0);
            check("b2b_pc", if_id_pc_o, 32'(i * 4));
            check("b2b_valid", if_id_valid_o, 1'b1);
        end

        // IF/ID stall while the response for pc 8 arrives
        do_reset();
        repeat (3) plain(1'b0, 1'b0);
        check("pre_stall_pc", if_id_pc_o, 32'h4);
        for (int i = 0; i < 3; i++) begin
            plain(1'b0, 1'b1);
            check("stall_hold_pc", if_id_pc_o, 32'h4);
            check("stall_state_hold", fetch_state_o, 2'd2);
            check("stall_no_req", last_req, 1'b0);
        end
        plain(1'b0, 1'b0);
        check("drain_no_req", last_req, 1'b0);
        check("drain_pc8", if_id_pc_o, 32'h8);
        check("drain_state_fetch", fetch_state_o, 2'd0);
        plain(1'b0, 1'b0);
        check("resume_req", last_req, 1'b1);
        check("resume_addr", last_addr, 32'hC);
        plain(1'b0, 1'b1);
        check("full_buf_state", fetch_state_o, 2'd2);
        do_reset();
        plain(1'b0, 1'b0);
        check("restart_addr", last_addr, 32'h0);

        // branch while waiting: the in-flight response must be dropped
        data_is_addr = 1'b0; lat_min = 2; lat_max = 2;
        do_reset();
        plain(1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 2'b01, 32'h100, 32'h0);
        check("redir_wait_state", fetch_state_o, 2'd1);
        plain(1'b0, 1'b0);
        check("discard_no_req", last_req, 1'b0);
        check("discard_state_fetch", fetch_state_o, 2'd0);
        plain(1'b0, 1'b0);
        check("target_req", last_req, 1'b1);
        check("target_addr", last_addr, 32'h100);
        plain(1'b0, 1'b0);
        check("target_still_bubble", if_id_valid_o, 1'b0);
        plain(1'b0, 1'b0);
        check("target_pc", if_id_pc_o, 32'h100);
        check("target_valid", if_id_valid_o, 1'b1);
        check("mid_wait_busy", fetch_busy_o, 1'b1);
        do_reset();
        plain(1'b0, 1'b0);
        check("mid_wait_restart_addr", last_addr, 32'h0);

        // JALR coincident with rvalid
        lat_min = 1; lat_max = 1;
        do_reset();
        plain(1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 2'b11, 32'h0, 32'h203);
        check("jalr_no_b2b", last_req, 1'b0);
        check("jalr_state_fetch", fetch_state_o, 2'd0);
        plain(1'b0, 1'b0);
        check("jalr_req", last_req, 1'b1);
        check("jalr_addr", last_addr, 32'h202);
        plain(1'b0, 1'b0);
        check("jalr_pc", if_id_pc_o, 32'h202);

        // pc_stall in FETCH, then a grant held off for 3 cycles
        do_reset();
        for (int i = 0; i < 2; i++) begin
            plain(1'b1, 1'b0);
            check("pc_stall_no_req", last_req, 1'b0);
            check("pc_stall_bubble", if_id_valid_o, 1'b0);
        end
        gnt_wait = 3;
        for (int i = 0; i < 4; i++) begin
            plain(1'b0, 1'b0);
            check("slow_gnt_req", last_req, 1'b1);
            check("slow_gnt_addr", last_addr, 32'h0);
        end
        check("slow_gnt_busy", fetch_busy_o, 1'b1);
        gnt_wait = 0;
        repeat (3) plain(1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 2'b00, 32'h0, 32'h0);
        check("flush_over_stall", if_id_valid_o, 1'b0);

        // randomized traffic against the stream reference, including PC wrap-around
        gnt_pct = 70; lat_min = 1; lat_max = 3;
        do_reset();
        loads = 0;
        for (int n = 0; n < 4000; n++) begin
            ps  = ($urandom_range(0, 99) < 20);
            ifs = ($urandom_range(0, 99) < 25);
            sel = ($urandom_range(0, 99) < 6) ? 2'($urandom_range(1, 3)) : 2'b00;
            fl  = (sel != 2'b00) && ($urandom_range(0, 1) == 1);
            bt  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : (32'($urandom_range(0, 4095)) << 2);
            jt  = bt | 32'($urandom_range(0, 1));
            step(ps, ifs, fl, sel, bt, jt);
        end
        check("random_progress", 32'(loads > 300), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
